crc_engine: RTL and testbench

Parametrised, multi-bit-per-cycle CRC generator/checker; next generation of the team's serial CRC-8 shift register. Consumes framed data beats over a valid/ready handshake and computes the CRC over a frame (first..last). Presents the final CRC plus a residue-check flag on a held valid/ready output. It sits between the serial/byte datapath and link-layer framing logic.

---
 rtl/crc_engine.sv | 153 +++++++++++++++
 tb/tb_crc_engine.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_engine.sv
// ---------------------------------------------------------------------------
// crc_engine
//
// Purpose:
//   Parametrised CRC generator/checker that consumes DATA_W bits per accepted
//   beat.  Frames are delimited by in_first/in_last.  When the last beat is
//   accepted, the final CRC and a residue-check flag are presented on a held
//   valid/ready output.  With the default parameters and DATA_W=1, the
//   register tracks the older serial CRC-8 shift register bit for bit.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   in_valid   - input beat present
//   in_ready   - engine can accept a beat (low while a result is held)
//   in_data    - beat data, bit DATA_W-1 processed first
//   in_first   - beat starts a frame
//   in_last    - beat ends a frame
//   out_ready  - consumer accepts the held result
//   crc_valid  - result available, held until out_ready
//   crc_out    - final CRC (register ^ XOROUT)
//   crc_ok     - final register equalled RESIDUE
//   frame_err  - sticky framing error flag
//   err_clr    - synchronous clear of frame_err (a new error wins)
// ---------------------------------------------------------------------------
module crc_engine #(
    parameter int              CRC_W   = 8,
    parameter logic [CRC_W-1:0] POLY    = 8'h1D,
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOROUT  = '0,
    parameter int              DATA_W  = 1,
    parameter logic [CRC_W-1:0] RESIDUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_first,
    input  logic              in_last,
    input  logic              out_ready,
    output logic              crc_valid,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_ok,
    output logic              frame_err,
    input  logic              err_clr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] crc_out_q, crc_out_d;
    logic             crc_ok_q, crc_ok_d;
    logic             frame_err_q, frame_err_d;

    logic             accept;
    logic             err_set;
    logic [CRC_W-1:0] next_crc;

    assign in_ready  = (state_q != HOLD);
    assign accept    = in_valid && in_ready;
    assign crc_valid = (state_q == HOLD);
    assign crc_out   = crc_out_q;
    assign crc_ok    = crc_ok_q;
    assign frame_err = frame_err_q;

    // Unrolled bit-serial update: a first beat always seeds from INIT, so a
    // restart inside RUN and a normal start in IDLE share the same path.
    always_comb begin
        next_crc = in_first ? INIT : crc_q;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (in_data[i] ^ next_crc[CRC_W-1]) begin
                next_crc = {next_crc[CRC_W-2:0], 1'b0} ^ POLY;
            end else begin
                next_crc = {next_crc[CRC_W-2:0], 1'b0};
            end
        end
    end

    // Frame sequencing.  A beat without in_first in IDLE has no frame to join,
    // so it is swallowed and flagged rather than stalled.  The result
    // registers only load on the edge that moves into HOLD.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        crc_ok_d  = crc_ok_q;
        err_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_first) begin
                        crc_d   = next_crc;
                        state_d = in_last ? HOLD : RUN;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    crc_d = next_crc;
                    if (in_first) begin
                        err_set = 1'b1;
                    end
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    crc_d   = INIT;
                end
            end
            default: begin
                state_d = IDLE;
                crc_d   = INIT;
            end
        endcase
        if ((state_q != HOLD) && (state_d == HOLD)) begin
            crc_out_d = next_crc ^ XOROUT;
            crc_ok_d  = (next_crc == RESIDUE);
        end
        frame_err_d = frame_err_q;
        if (err_set) begin
            frame_err_d = 1'b1;
        end else if (err_clr) begin
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            crc_out_q   <= '0;
            crc_ok_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            crc_out_q   <= crc_out_d;
            crc_ok_q    <= crc_ok_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_crc_engine.sv
// ---------------------------------------------------------------------------
// tb_crc_engine
//
// Purpose:
//   Directed bench for crc_engine.  Two instances run side by side: one
//   byte-wide (DATA_W=8) and one bit-serial (DATA_W=1), both with the default
//   CRC-8 polynomial 0x1D.  Expected results are pushed into per-instance
//   queues when a frame is issued; monitors pop and compare on each output
//   handshake.
// ---------------------------------------------------------------------------
module tb_crc_engine;

    typedef struct packed {
        logic [7:0] crc;
        logic       ok;
    } expect_t;

    logic clk = 1'b0;
    logic reset;

    logic       inValid8, inReady8, inFirst8, inLast8, outReady8;
    logic [7:0] inData8;
    logic       crcValid8, crcOk8, frameErr8, errClr8;
    logic [7:0] crcOut8;

    logic       inValid1, inReady1, inFirst1, inLast1, outReady1;
    logic [0:0] inData1;
    logic       crcValid1, crcOk1, frameErr1, errClr1;
    logic [7:0] crcOut1;

    expect_t q8[$];
    expect_t q1[$];

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    crc_engine #(.DATA_W(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(inValid8), .in_ready(inReady8), .in_data(inData8),
        .in_first(inFirst8), .in_last(inLast8), .out_ready(outReady8),
        .crc_valid(crcValid8), .crc_out(crcOut8), .crc_ok(crcOk8),
        .frame_err(frameErr8), .err_clr(errClr8)
    );

    crc_engine #(.DATA_W(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(inValid1), .in_ready(inReady1), .in_data(inData1),
        .in_first(inFirst1), .in_last(inLast1), .out_ready(outReady1),
        .crc_valid(crcValid1), .crc_out(crcOut1), .crc_ok(crcOk1),
        .frame_err(frameErr1), .err_clr(errClr1)
    );

    // One comparison: counts it and reports a mismatch on a single line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitors: a result is consumed on each valid && ready seen mid-cycle.
    always @(negedge clk) begin
        if (crcValid8 && outReady8) begin
            if (q8.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_result8: got crc 0x%0h, expected no result", crcOut8);
            end else begin
                expect_t e;
                e = q8.pop_front();
                checkOutput("crc_out8", {24'd0, crcOut8}, {24'd0, e.crc});
                checkOutput("crc_ok8", {31'd0, crcOk8}, {31'd0, e.ok});
            end
        end
    end

    always @(negedge clk) begin
        if (crcValid1 && outReady1) begin
            if (q1.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_result1: got crc 0x%0h, expected no result", crcOut1);
            end else begin
                expect_t e;
                e = q1.pop_front();
                checkOutput("crc_out1", {24'd0, crcOut1}, {24'd0, e.crc});
                checkOutput("crc_ok1", {31'd0, crcOk1}, {31'd0, e.ok});
            end
        end
    end

    // Offers a byte beat and returns one cycle after it has been accepted.
    task automatic applyStimulus8(input logic [7:0] d, input logic f, input logic l);
        int n;
        inValid8 = 1'b1;
        inData8  = d;
        inFirst8 = f;
        inLast8  = l;
        n = 0;
        @(negedge clk);
        while (!inReady8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL accept8_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
        inValid8 = 1'b0;
        inFirst8 = 1'b0;
        inLast8  = 1'b0;
    endtask

    task automatic applyStimulus1(input logic b, input logic f, input logic l);
        int n;
        inValid1 = 1'b1;
        inData1  = b;
        inFirst1 = f;
        inLast1  = l;
        n = 0;
        @(negedge clk);
        while (!inReady1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL accept1_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
        inValid1 = 1'b0;
        inFirst1 = 1'b0;
        inLast1  = 1'b0;
    endtask

    task automatic sendByte1(input logic [7:0] d, input logic f, input logic l);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus1(d[i], f && (i == 7), l && (i == 0));
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain_timeout: %0d/%0d results pending, expected 0", q8.size(), q1.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulseErrClr8();
        errClr8 = 1'b1;
        @(posedge clk);
        #1;
        errClr8 = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        inValid8  = 1'b0; inData8 = '0; inFirst8 = 1'b0; inLast8 = 1'b0;
        outReady8 = 1'b1; errClr8 = 1'b0;
        inValid1  = 1'b0; inData1 = '0; inFirst1 = 1'b0; inLast1 = 1'b0;
        outReady1 = 1'b1; errClr1 = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_crc_valid", {31'd0, crcValid8}, 32'd0);
        checkOutput("rst_crc_out", {24'd0, crcOut8}, 32'd0);
        checkOutput("rst_crc_ok", {31'd0, crcOk8}, 32'd0);
        checkOutput("rst_frame_err", {31'd0, frameErr8}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, inReady8}, 32'd1);
        checkOutput("rst_crc_valid1", {31'd0, crcValid1}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single-beat frames and a two-beat residue check.
        q8.push_back('{crc: 8'h1D, ok: 1'b0});
        applyStimulus8(8'h01, 1'b1, 1'b1);
        waitDrain();
        q8.push_back('{crc: 8'h26, ok: 1'b0});
        applyStimulus8(8'h80, 1'b1, 1'b1);
        waitDrain();
        q8.push_back('{crc: 8'h3A, ok: 1'b0});
        applyStimulus8(8'h02, 1'b1, 1'b1);
        waitDrain();
        q8.push_back('{crc: 8'h00, ok: 1'b1});
        applyStimulus8(8'h01, 1'b1, 1'b0);
        applyStimulus8(8'h1D, 1'b0, 1'b1);
        waitDrain();
        q8.push_back('{crc: 8'h1D, ok: 1'b0});
        applyStimulus8(8'h01, 1'b1, 1'b0);
        applyStimulus8(8'h1C, 1'b0, 1'b1);
        waitDrain();

        // Backpressure: result must hold and an offered beat must not enter.
        outReady8 = 1'b0;
        q8.push_back('{crc: 8'h26, ok: 1'b0});
        applyStimulus8(8'h80, 1'b1, 1'b1);
        inValid8 = 1'b1; inData8 = 8'h01; inFirst8 = 1'b1; inLast8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_crc_valid", {31'd0, crcValid8}, 32'd1);
            checkOutput("hold_crc_out", {24'd0, crcOut8}, 32'h26);
            checkOutput("hold_in_ready", {31'd0, inReady8}, 32'd0);
        end
        @(posedge clk);
        #1;
        inValid8 = 1'b0; inFirst8 = 1'b0; inLast8 = 1'b0;
        outReady8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("release_crc_valid", {31'd0, crcValid8}, 32'd0);
        checkOutput("release_in_ready", {31'd0, inReady8}, 32'd1);
        checkOutput("release_crc_out_kept", {24'd0, crcOut8}, 32'h26);
        repeat (3) @(negedge clk);
        checkOutput("no_extra_result", {31'd0, crcValid8}, 32'd0);
        @(posedge clk);
        #1;

        // Framing errors: orphan beat in IDLE, then restart inside RUN.
        applyStimulus8(8'h55, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("orphan_frame_err", {31'd0, frameErr8}, 32'd1);
        checkOutput("orphan_no_result", {31'd0, crcValid8}, 32'd0);
        @(posedge clk);
        #1;
        pulseErrClr8();
        @(negedge clk);
        checkOutput("err_clr", {31'd0, frameErr8}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus8(8'h55, 1'b1, 1'b0);
        q8.push_back('{crc: 8'h1D, ok: 1'b0});
        applyStimulus8(8'h01, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("restart_frame_err", {31'd0, frameErr8}, 32'd1);
        waitDrain();
        pulseErrClr8();
        @(negedge clk);
        checkOutput("err_clr2", {31'd0, frameErr8}, 32'd0);
        @(posedge clk);
        #1;
        errClr8 = 1'b1;
        applyStimulus8(8'h33, 1'b0, 1'b0);
        errClr8 = 1'b0;
        @(negedge clk);
        checkOutput("set_beats_clear", {31'd0, frameErr8}, 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-frame discards the partial frame and clears the flags.
        applyStimulus8(8'h01, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("midrst_crc_valid", {31'd0, crcValid8}, 32'd0);
        checkOutput("midrst_crc_out", {24'd0, crcOut8}, 32'd0);
        checkOutput("midrst_frame_err", {31'd0, frameErr8}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q8.push_back('{crc: 8'h26, ok: 1'b0});
        applyStimulus8(8'h80, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("post_rst_frame_err", {31'd0, frameErr8}, 32'd0);
        waitDrain();

        // Bit-serial instance must agree with the byte-wide results.
        q1.push_back('{crc: 8'h26, ok: 1'b0});
        sendByte1(8'h80, 1'b1, 1'b1);
        waitDrain();
        q1.push_back('{crc: 8'h00, ok: 1'b1});
        sendByte1(8'h01, 1'b1, 1'b0);
        sendByte1(8'h1D, 1'b0, 1'b1);
        waitDrain();

        checkOutput("queue8_empty", q8.size(), 32'd0);
        checkOutput("queue1_empty", q1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
